// File: rtl/ptl_link_pkg.sv
// -----------------------------------------------------------------------------
// ptl_link_pkg
//   Definitions shared by the PTL link receiver and transmitter.
//   - rx_state_e   : deframer state encoding (IDLE, DATA, PAR, STOP)
//   - frame_slots  : slots per frame (start + data + optional parity + stop)
//   - FRAME_SLOTS  : frame_slots() for the default 8-bit, parity-on link
//   - even_parity  : parity bit that makes the total count of ones even
// -----------------------------------------------------------------------------
package ptl_link_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_PAR  = 2'd2,
      ST_STOP = 2'd3
   } rx_state_e;

   function automatic int frame_slots(input int data_w, input int parity_en);
      return 1 + data_w + parity_en + 1;
   endfunction

   localparam int FRAME_SLOTS = frame_slots(8, 1);

   // Unused upper bits must be zero; they do not change the result.
   function automatic logic even_parity(input logic [31:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/ptl_delay_line.sv
// -----------------------------------------------------------------------------
// ptl_delay_line
//   Models the PTL propagation delay as a DEPTH-stage shift register.
//   With DEPTH = 0 the input passes straight through.
//   Ports:
//     clk - slot clock
//     rst - asynchronous, active-high reset; clears every stage
//     d   - pulse strobe entering the line
//     q   - pulse strobe leaving the line, DEPTH slots later
// -----------------------------------------------------------------------------
module ptl_delay_line #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign q = d;
      end else begin : g_shift
         logic [DEPTH-1:0] sr_q;
         logic [DEPTH-1:0] sr_d;

         // New slot enters at bit 0 and leaves from the top bit.
         always_comb begin
            sr_d = (sr_q << 1) | DEPTH'(d);
         end

         // NOTE: state registers use non-blocking assignments, so every flop
         // samples the values from before the clock edge.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sr_q <= '0;
            else     sr_q <= sr_d;
         end

         assign q = sr_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/ptl_link_rx.sv
// -----------------------------------------------------------------------------
// ptl_link_rx
//   Receiver at the far end of a PTL serial link. It delays the incoming pulse
//   stream by the line delay, deframes start/data/parity/stop slots and hands
//   each good word over through a valid/ready holding register.
//   Ports:
//     clk        - slot clock
//     rst        - asynchronous, active-high reset
//     din        - 1 = SFQ pulse arrived in this slot
//     dout       - received word, LSB received first
//     dout_valid - dout holds an unconsumed word
//     dout_ready - consumer takes dout when dout_valid && dout_ready
//     frame_err  - one-cycle pulse: stop slot carried a pulse
//     par_err    - one-cycle pulse: even-parity mismatch
//     overrun    - sticky: a good word was dropped because dout was full
//     busy       - deframer is not in IDLE
// -----------------------------------------------------------------------------
module ptl_link_rx
   import ptl_link_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int LINK_DELAY = 2,
   parameter int PARITY_EN  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              frame_err,
   output logic              par_err,
   output logic              overrun,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic ld;

   ptl_delay_line #(
      .DEPTH (LINK_DELAY)
   ) u_delay (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (ld)
   );

   rx_state_e         state_q,      state_d;
   logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
   logic [DATA_W-1:0] shreg_q,      shreg_d;
   logic              par_acc_q,    par_acc_d;
   logic              par_bad_q,    par_bad_d;
   logic [DATA_W-1:0] dout_q,       dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              frame_err_q,  frame_err_d;
   logic              par_err_q,    par_err_d;
   logic              overrun_q,    overrun_d;
   logic              word_load;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      par_acc_d    = par_acc_q;
      par_bad_d    = par_bad_q;
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      frame_err_d  = 1'b0;
      par_err_d    = 1'b0;
      overrun_d    = overrun_q;
      word_load    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ld) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
               par_acc_d = 1'b0;
               par_bad_d = 1'b0;
            end
         end

         ST_DATA: begin
            // LSB arrives first: each new bit enters at the top and the word
            // slides down, so the first bit ends up in bit 0.
            shreg_d   = (shreg_q >> 1) | (DATA_W'(ld) << (DATA_W - 1));
            par_acc_d = par_acc_q ^ ld;
            bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
               state_d = (PARITY_EN != 0) ? ST_PAR : ST_STOP;
            end
         end

         ST_PAR: begin
            par_bad_d = ld ^ par_acc_q;
            state_d   = ST_STOP;
         end

         ST_STOP: begin
            // A pulse here is a framing error, never a new start slot.
            state_d = ST_IDLE;
            if (ld)                               frame_err_d = 1'b1;
            else if (par_bad_q)                   par_err_d   = 1'b1;
            else if (!dout_valid_q || dout_ready) word_load   = 1'b1;
            else                                  overrun_d   = 1'b1;
         end

         default: state_d = ST_IDLE;
      endcase

      // A load in the same cycle as an acceptance keeps dout_valid high.
      if (word_load) begin
         dout_d       = shreg_q;
         dout_valid_d = 1'b1;
      end else if (dout_valid_q && dout_ready) begin
         dout_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         par_acc_q    <= 1'b0;
         par_bad_q    <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         par_err_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         par_acc_q    <= par_acc_d;
         par_bad_q    <= par_bad_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         frame_err_q  <= frame_err_d;
         par_err_q    <= par_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign frame_err  = frame_err_q;
   assign par_err    = par_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ptl_link_rx.sv
// -----------------------------------------------------------------------------
// tb_ptl_link_rx
//   Self-checking bench for ptl_link_rx (DATA_W=8, LINK_DELAY=2, PARITY_EN=1).
//   A slot-history model reassembles each frame from the delayed pulse stream
//   and predicts every output; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_ptl_link_rx;

   localparam int DW   = 8;
   localparam int LD   = 2;
   localparam int PE   = 1;
   localparam int FS   = 1 + DW + PE + 1;
   localparam int HIST = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          din = 1'b0;
   logic          dout_ready = 1'b0;
   logic [DW-1:0] dout;
   logic          dout_valid;
   logic          frame_err;
   logic          par_err;
   logic          overrun;
   logic          busy;

   always #5 clk = ~clk;

   ptl_link_rx #(
      .DATA_W     (DW),
      .LINK_DELAY (LD),
      .PARITY_EN  (PE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_err  (frame_err),
      .par_err    (par_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // din and ld histories since the last reset; a frame is judged as a whole
   // once its stop slot has come out of the line.
   bit            dh [HIST];
   bit            lh [HIST];
   int            m_t;
   bit            m_in_frame;
   int            m_fstart;
   logic [DW-1:0] m_dout;
   bit            m_vld, m_ov, m_fe, m_pe, m_busy;

   function automatic void model_reset();
      m_t = 0; m_in_frame = 0; m_fstart = 0;
      m_dout = '0; m_vld = 0; m_ov = 0; m_fe = 0; m_pe = 0; m_busy = 0;
      for (int i = 0; i < HIST; i++) begin
         dh[i] = 0;
         lh[i] = 0;
      end
   endfunction

   function automatic void model_edge(input bit d, input bit rdy);
      bit            ld, perr, good, load, pbit;
      logic [DW-1:0] word;
      dh[m_t % HIST] = d;
      ld = (m_t >= LD) ? dh[(m_t - LD) % HIST] : 1'b0;
      lh[m_t % HIST] = ld;
      m_fe = 0; m_pe = 0; good = 0; load = 0;
      if (!m_in_frame) begin
         if (ld) begin
            m_in_frame = 1;
            m_fstart   = m_t;
         end
      end else if (m_t == m_fstart + FS - 1) begin
         word = '0;
         for (int i = 0; i < DW; i++) word[i] = lh[(m_fstart + 1 + i) % HIST];
         pbit = lh[(m_fstart + 1 + DW) % HIST];
         perr = (PE != 0) && (pbit != ($countones(word) % 2 == 1));
         if (ld)        m_fe = 1;
         else if (perr) m_pe = 1;
         else           good = 1;
         load = good && (!m_vld || rdy);
         if (good && !load) m_ov = 1;
         m_in_frame = 0;
      end
      if (load) begin
         m_dout = word;
         m_vld  = 1;
      end else if (m_vld && rdy) begin
         m_vld = 0;
      end
      m_busy = m_in_frame;
      m_t++;
   endfunction

   // ---------------- compare process ----------------
   bit            cmp_en = 0;
   int            cyc = 0;
   int            fe_cnt, pe_cnt, vld_cnt;
   bit            prev_vld = 0;
   int            rise_cyc [$];
   logic [DW-1:0] rise_word [$];

   always @(negedge clk) begin
      if (cmp_en) begin
         check("dout_valid", 32'(dout_valid), 32'(m_vld));
         check("dout",       32'(dout),       32'(m_dout));
         check("frame_err",  32'(frame_err),  32'(m_fe));
         check("par_err",    32'(par_err),    32'(m_pe));
         check("overrun",    32'(overrun),    32'(m_ov));
         check("busy",       32'(busy),       32'(m_busy));
         if (frame_err === 1'b1) fe_cnt++;
         if (par_err === 1'b1)   pe_cnt++;
         if (dout_valid === 1'b1) vld_cnt++;
         if (dout_valid === 1'b1 && !prev_vld) begin
            rise_cyc.push_back(cyc);
            rise_word.push_back(dout);
         end
         prev_vld = (dout_valid === 1'b1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input bit d, input bit r);
      din        = d;
      dout_ready = r;
      @(posedge clk);
      model_edge(d, r);
      cyc++;
      #1;
   endtask

   // ready_mode: 0/1 = fixed ready level, 2 = random per slot
   task automatic send_frame(input logic [DW-1:0] w, input bit par_flip,
                             input bit stop_bit, input int ready_mode);
      bit slots [FS];
      int k;
      k = 0;
      slots[k++] = 1'b1;
      for (int i = 0; i < DW; i++) slots[k++] = w[i];
      if (PE != 0) slots[k++] = (^w) ^ par_flip;
      slots[k] = stop_bit;
      for (int i = 0; i < FS; i++) begin
         if (ready_mode == 2) step(slots[i], ($urandom % 4) != 0);
         else                 step(slots[i], ready_mode[0]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din = 1'b0;
      dout_ready = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic clear_stats();
      fe_cnt = 0; pe_cnt = 0; vld_cnt = 0;
      rise_cyc.delete();
      rise_word.delete();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [DW-1:0] w5a;
      logic [DW-1:0] rw;
      bit            rflip, rstop;
      int            gap;

      model_reset();
      clear_stats();
      cmp_en = 1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_dout_valid", 32'(dout_valid), 0);
      check("rst_dout",       32'(dout),       0);
      check("rst_overrun",    32'(overrun),    0);
      check("rst_busy",       32'(busy),       0);

      // Good frame 0xA5: valid appears 12 edges after the start slot is sampled
      clear_stats();
      send_frame(8'hA5, 0, 0, 1);
      step(0, 1);
      check("a5_not_yet_valid", 32'(dout_valid), 0);
      step(0, 1);
      check("a5_valid", 32'(dout_valid), 1);
      check("a5_dout",  32'(dout), 32'h0A5);
      step(0, 1);
      check("a5_valid_cleared", 32'(dout_valid), 0);
      check("a5_valid_cycles",  32'(vld_cnt), 1);
      check("a5_no_errors",     32'(fe_cnt + pe_cnt), 0);

      // Parity slot flipped
      clear_stats();
      send_frame(8'hA5, 1, 0, 1);
      repeat (3) step(0, 1);
      check("par_err_pulses", 32'(pe_cnt), 1);
      check("par_no_word",    32'(vld_cnt), 0);
      check("par_idle",       32'(busy), 0);

      // Stop slot pulsed, next frame starts in the very next slot
      clear_stats();
      send_frame(8'h3C, 0, 1, 1);
      send_frame(8'h01, 0, 0, 1);
      repeat (3) step(0, 1);
      check("ferr_pulses",      32'(fe_cnt), 1);
      check("ferr_words",       32'(rise_word.size()), 1);
      check("ferr_next_word",   32'(dout), 32'h01);

      // Holding register full: second word dropped, overrun sticks
      clear_stats();
      send_frame(8'h11, 0, 0, 0);
      send_frame(8'h22, 0, 0, 0);
      repeat (3) step(0, 0);
      check("ovr_dout_held",  32'(dout), 32'h11);
      check("ovr_valid_held", 32'(dout_valid), 1);
      check("ovr_flag",       32'(overrun), 1);
      step(0, 1);
      check("ovr_accepted",   32'(dout_valid), 0);
      check("ovr_sticky",     32'(overrun), 1);

      // Back-to-back frames
      do_reset();
      clear_stats();
      send_frame(8'h01, 0, 0, 1);
      send_frame(8'hFF, 0, 0, 1);
      repeat (3) step(0, 1);
      check("b2b_words", 32'(rise_word.size()), 2);
      if (rise_word.size() == 2) begin
         check("b2b_spacing", 32'(rise_cyc[1] - rise_cyc[0]), 11);
         check("b2b_word0",   32'(rise_word[0]), 32'h01);
         check("b2b_word1",   32'(rise_word[1]), 32'hFF);
      end

      // Reset in the middle of the data slots of 0x5A
      clear_stats();
      w5a = 8'h5A;
      step(1, 1);
      for (int i = 0; i < 4; i++) step(w5a[i], 1);
      do_reset();
      send_frame(8'h0F, 0, 0, 1);
      repeat (3) step(0, 1);
      check("rstmid_words",  32'(rise_word.size()), 1);
      if (rise_word.size() == 1) check("rstmid_word", 32'(rise_word[0]), 32'h0F);
      check("rstmid_errors", 32'(fe_cnt + pe_cnt), 0);

      // Randomised frames, corruptions, gaps and consumer stalls
      do_reset();
      clear_stats();
      for (int n = 0; n < 300; n++) begin
         rw    = DW'($urandom);
         rflip = ($urandom % 8) == 0;
         rstop = ($urandom % 8) == 0;
         gap   = $urandom % 3;
         send_frame(rw, rflip, rstop, 2);
         for (int g = 0; g < gap; g++) step(0, ($urandom % 4) != 0);
      end
      repeat (FS + LD + 2) step(0, 1);

      cmp_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
